// File: rtl/iic_cfg_arbiter.sv
// iic_cfg_arbiter: shares one byte-level IIC register-access master between
// NREQ configuration requesters. Round-robin with optional burst lock, one
// command in flight, timeout supervision, optional inter-command gap.
// Optional NACK retry is built only when IIC_CFG_ARB_RETRY_EN is defined.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no owner; pick the next requester and latch its command
// ISSUE  | one-cycle m_start strobe, timeout counter cleared
// WAIT   | wait for m_done, abort when the timeout counter expires
// RESP   | one-cycle ack to the owner, rsp_* valid
// GAP    | GAP_CYC quiet cycles before the next command (owner still shown)
module iic_cfg_arbiter #(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 20000,
  parameter int GAP_CYC     = 4,
  parameter int MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_lock,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [NREQ*7-1:0] req_dev,
  input  logic [NREQ*16-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_wdata,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic [NREQ-1:0]   gnt_oh,
  output logic              busy,
  output logic              m_start,
  output logic              m_rw,
  output logic [6:0]        m_dev,
  output logic [15:0]       m_addr,
  output logic [7:0]        m_wdata,
  output logic              m_abort,
  input  logic              m_done,
  input  logic              m_nack,
  input  logic [7:0]        m_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 2);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_GAP} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q;
  logic            own_vld_q;
  logic [NREQ-1:0] gnt_q;
  logic            m_rw_q;
  logic [6:0]      m_dev_q;
  logic [15:0]     m_addr_q;
  logic [7:0]      m_wdata_q;
  logic [7:0]      rsp_rdata_q;
  logic [1:0]      rsp_err_q;
  logic [TW-1:0]   tmo_q;
  logic [GW-1:0]   gap_q;
  logic            sel_vld;
  logic [PW-1:0]   sel_idx;
  logic [PW-1:0]   cand;
  logic            tmo_hit;
  logic            gap_hit;
  logic            retry_now;
  logic            retry_pend;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));
  assign gap_hit = (gap_q == GW'(GAP_CYC - 1));

`ifdef IIC_CFG_ARB_RETRY_EN
  logic [7:0] retry_q;
  logic       retry_pend_q;

  assign retry_now  = m_done && m_nack && (int'(retry_q) < MAX_RETRY);
  assign retry_pend = retry_pend_q;

  // Retry bookkeeping: count NACK retries of the latched command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q      <= '0;
      retry_pend_q <= 1'b0;
    end else if (state_q == S_IDLE && sel_vld) begin
      retry_q      <= '0;
      retry_pend_q <= 1'b0;
    end else if (state_q == S_ISSUE) begin
      retry_pend_q <= 1'b0;
    end else if (state_q == S_WAIT && retry_now) begin
      retry_q      <= retry_q + 8'd1;
      retry_pend_q <= 1'b1;
    end
  end
`else
  logic unused_retry;
  assign unused_retry = (MAX_RETRY < 0);
  assign retry_now    = 1'b0;
  assign retry_pend   = 1'b0;
`endif

  // Requester selection: locked owner first, else round-robin after ptr_q.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = ptr_q;
    cand    = ptr_q;
    if (own_vld_q && req[ptr_q] && req_lock[ptr_q]) begin
      sel_vld = 1'b1;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = PW'((int'(ptr_q) + k) % NREQ);
        if (!sel_vld && req[cand]) begin
          sel_vld = 1'b1;
          sel_idx = cand;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (sel_vld) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (m_done) begin
          if (retry_now) state_d = (GAP_CYC == 0) ? S_ISSUE : S_GAP;
          else           state_d = S_RESP;
        end else if (tmo_hit) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = (GAP_CYC == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (gap_hit) state_d = retry_pend ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    busy    = (state_q != S_IDLE);
    m_start = (state_q == S_ISSUE);
    m_abort = (state_q == S_WAIT) && tmo_hit && !m_done;
    ack     = (state_q == S_RESP) ? gnt_q : '0;
  end

  // Datapath: command latch, grant, pointer, counters and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= PW'(NREQ - 1);
      own_vld_q   <= 1'b0;
      gnt_q       <= '0;
      m_rw_q      <= 1'b0;
      m_dev_q     <= '0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= '0;
      tmo_q       <= '0;
      gap_q       <= '0;
    end else begin
      if (state_q == S_IDLE && sel_vld) begin
        m_rw_q    <= req_rw[sel_idx];
        m_dev_q   <= req_dev[int'(sel_idx)*7 +: 7];
        m_addr_q  <= req_addr[int'(sel_idx)*16 +: 16];
        m_wdata_q <= req_wdata[int'(sel_idx)*8 +: 8];
        gnt_q     <= {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
        ptr_q     <= sel_idx;
        own_vld_q <= 1'b1;
      end else if (state_d == S_IDLE) begin
        gnt_q <= '0;
      end
      if (state_q == S_ISSUE) tmo_q <= '0;
      else if (state_q == S_WAIT && !tmo_hit) tmo_q <= tmo_q + 1'b1;
      if (state_q == S_WAIT) begin
        if (m_done && !retry_now) begin
          rsp_rdata_q <= m_rdata;
          rsp_err_q   <= m_nack ? 2'b01 : 2'b00;
        end else if (!m_done && tmo_hit) begin
          rsp_err_q   <= 2'b10;
        end
      end
      if (state_q == S_GAP) gap_q <= gap_q + 1'b1;
      else                  gap_q <= '0;
    end
  end

  assign gnt_oh    = gnt_q;
  assign m_rw      = m_rw_q;
  assign m_dev     = m_dev_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_iic_cfg_arbiter.sv
// Directed bench for iic_cfg_arbiter: single command, fairness, lock burst,
// timeout vs. coincident done, reset mid-WAIT, and NACK retry when built
// with IIC_CFG_ARB_RETRY_EN.
module tb_iic_cfg_arbiter;

  localparam int NREQ = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0, req_lock = '0, req_rw = '0;
  logic [13:0] req_dev = '0;
  logic [31:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  ack, rsp_err, gnt_oh;
  logic [7:0]  rsp_rdata, m_wdata, m_rdata = '0;
  logic        busy, m_start, m_rw, m_abort;
  logic [6:0]  m_dev;
  logic [15:0] m_addr;
  logic        m_done = 1'b0, m_nack = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int s, prev, c0, nstart;

  iic_cfg_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(100), .GAP_CYC(4), .MAX_RETRY(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_lock(req_lock), .req_rw(req_rw),
    .req_dev(req_dev), .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .gnt_oh(gnt_oh),
    .busy(busy), .m_start(m_start), .m_rw(m_rw), .m_dev(m_dev), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_abort(m_abort), .m_done(m_done), .m_nack(m_nack),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_cmd(input int i, input logic rw, input logic [6:0] dev,
                         input logic [15:0] addr, input logic [7:0] wd);
    req_rw[i]            = rw;
    req_dev[i*7 +: 7]    = dev;
    req_addr[i*16 +: 16] = addr;
    req_wdata[i*8 +: 8]  = wd;
  endtask

  task automatic wait_start(output int sc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_start && n < 300);
    chk("start_seen", m_start, 1);
    sc = cyc;
  endtask

  // Called at the m_start negedge; raises m_done d cycles later, returns at the ack cycle.
  task automatic serve(input int d, input logic nack, input logic [7:0] rd);
    repeat (d) @(negedge clk);
    m_done = 1'b1; m_nack = nack; m_rdata = rd; #1;
    chk("no_abort_on_done", m_abort, 0);
    @(negedge clk);
    m_done = 1'b0; m_nack = 1'b0; m_rdata = '0; #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ack, gnt_oh, busy, m_start, m_abort, rsp_err, rsp_rdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single write
    set_cmd(0, 1'b0, 7'h2B, 16'h1234, 8'h5A);
    req = 2'b01; c0 = cyc;
    wait_start(s);
    chk("t1_start_lat", s - c0, 1);
    chk("t1_fields", {m_rw, m_dev, m_addr, m_wdata}, {1'b0, 7'h2B, 16'h1234, 8'h5A});
    chk("t1_gnt", gnt_oh, 2'b01);
    chk("t1_busy", busy, 1);
    serve(10, 1'b0, 8'h00);
    chk("t1_ack_lat", cyc - s, 11);
    chk("t1_ack", ack, 2'b01);
    chk("t1_err", rsp_err, 2'b00);
    req = 2'b00;

    // 2: fairness with both requesters held from reset
    set_cmd(0, 1'b0, 7'h10, 16'h0001, 8'h11);
    set_cmd(1, 1'b0, 7'h20, 16'h0002, 8'h22);
    req = 2'b11;
    do_reset();
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_start(s);
      chk("t2_gnt", gnt_oh, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) chk("t2_spacing", s - prev, 12);
      prev = s;
      serve(5, 1'b0, 8'h00);
      chk("t2_ack", ack, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    req = 2'b00;

    // 3: lock burst by requester 0 while requester 1 waits
    req_lock = 2'b01;
    req = 2'b11;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      wait_start(s);
      chk("t3_lock_gnt", gnt_oh, 2'b01);
      serve(3, 1'b0, 8'h00);
      chk("t3_ack", ack, 2'b01);
      if (k == 2) req[0] = 1'b0;
    end
    wait_start(s);
    chk("t3_then_r1", gnt_oh, 2'b10);
    serve(3, 1'b0, 8'h00);
    chk("t3_ack1", ack, 2'b10);
    req = 2'b00; req_lock = 2'b00;

    // 5: read whose m_done lands on the timeout cycle
    set_cmd(0, 1'b1, 7'h50, 16'h0010, 8'h00);
    req = 2'b01;
    wait_start(s);
    chk("t5_rw", m_rw, 1);
    chk("t5_gnt", gnt_oh, 2'b01);
    serve(100, 1'b0, 8'hC3);
    chk("t5_ack", ack, 2'b01);
    chk("t5_rdata", rsp_rdata, 8'hC3);
    chk("t5_err", rsp_err, 2'b00);
    req = 2'b00;

    // 4: timeout, master silent
    set_cmd(1, 1'b1, 7'h51, 16'h0020, 8'h00);
    req = 2'b10;
    wait_start(s);
    chk("t4_gnt", gnt_oh, 2'b10);
    repeat (99) @(negedge clk);
    chk("t4_no_early_abort", m_abort, 0);
    @(negedge clk);
    chk("t4_abort", m_abort, 1);
    chk("t4_abort_cycle", cyc - s, 100);
    @(negedge clk);
    chk("t4_abort_one_cycle", m_abort, 0);
    chk("t4_ack", ack, 2'b10);
    chk("t4_err", rsp_err, 2'b10);
    chk("t4_rdata_kept", rsp_rdata, 8'hC3);
    req = 2'b00;

    // 6: reset in WAIT with requester 1 pending
    set_cmd(0, 1'b0, 7'h11, 16'hAAAA, 8'h01);
    set_cmd(1, 1'b0, 7'h22, 16'hBBBB, 8'h02);
    req = 2'b11;
    wait_start(s);
    chk("t6_gnt0", gnt_oh, 2'b01);
    repeat (3) @(negedge clk);
    rst_n = 1'b0; req = 2'b00; #1;
    chk("t6_rst_outputs", {ack, gnt_oh, busy, m_start, m_abort, rsp_err, rsp_rdata,
                           m_rw, m_dev, m_addr, m_wdata}, 0);
    repeat (2) @(negedge clk);
    chk("t6_rst_no_ack", {ack, busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    req = 2'b11;
    wait_start(s);
    chk("t6_after_gnt0", gnt_oh, 2'b01);
    serve(2, 1'b0, 8'h00);
    chk("t6_ack0", ack, 2'b01);
    req[0] = 1'b0;
    wait_start(s);
    chk("t6_after_gnt1", gnt_oh, 2'b10);
    serve(2, 1'b0, 8'h00);
    chk("t6_ack1", ack, 2'b10);
    req = 2'b00;

`ifdef IIC_CFG_ARB_RETRY_EN
    // Retry: two NACKs then ok -> three m_starts, one ack
    set_cmd(0, 1'b0, 7'h33, 16'h0303, 8'h33);
    req = 2'b01;
    for (int k = 0; k < 3; k++) begin
      wait_start(s);
      chk("rt_gnt", gnt_oh, 2'b01);
      chk("rt_fields", {m_dev, m_addr}, {7'h33, 16'h0303});
      serve(4, (k < 2), 8'h00);
      chk("rt_ack", ack, (k < 2) ? 2'b00 : 2'b01);
    end
    chk("rt_err", rsp_err, 2'b00);
    req = 2'b00;
    nstart = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_start) nstart++;
    end
    chk("rt_no_extra_start", nstart, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
